// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Bundles the E-stage HI/LO request and the unit's response.
//   master: issuing side (E stage / testbench) drives start, md_op, rs_val, rt_val.
//   slave : mul_div_unit, drives busy, hi_out, lo_out.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (output start, md_op, rs_val, rt_val,
                  input  busy, hi_out, lo_out);
  modport slave  (input  start, md_op, rs_val, rt_val,
                  output busy, hi_out, lo_out);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multi-cycle HI/LO multiply/divide unit for the E stage.
//   The result is computed at the start edge into a pending register, then held
//   back for MUL_CYCLES / DIV_CYCLES busy cycles before it lands in HI/LO.
//   HI/LO therefore keep their old values while busy is high.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous reset, active low
//   io     : mul_div_unit_if.slave
//            start/md_op/rs_val/rt_val in, busy/hi_out/lo_out out
//   md_op  : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  io
);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  state_t        state;
  logic [CW-1:0] cnt;
  hilo_t         pend;
  hilo_t         arch;
  logic          busy_q;

  // ---------------- multiply ----------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{io.rs_val[31]}}, io.rs_val}) *
                  $signed({{32{io.rt_val[31]}}, io.rt_val});
  assign prod_u = {32'd0, io.rs_val} * {32'd0, io.rt_val};

  // ---------------- divide ----------------
  // One unsigned divider serves both DIV and DIVU. For DIV the operands are
  // reduced to magnitudes and signs are restored afterwards; this also gives
  // 0x80000000 / -1 = 0x80000000 (rem 0) without any overflow special case.
  logic        is_sdiv;
  logic        rs_neg, rt_neg;
  logic [31:0] num, den, den_g, q_u, r_u, quo, rem;
  logic        div0;

  assign is_sdiv = (io.md_op == 3'd2);
  assign rs_neg  = is_sdiv & io.rs_val[31];
  assign rt_neg  = is_sdiv & io.rt_val[31];
  assign num     = rs_neg ? (32'd0 - io.rs_val) : io.rs_val;
  assign den     = rt_neg ? (32'd0 - io.rt_val) : io.rt_val;
  assign div0    = (io.rt_val == 32'd0);
  // Keep the divider away from a zero divisor; the result is discarded anyway.
  assign den_g   = div0 ? 32'd1 : den;
  assign q_u     = num / den_g;
  assign r_u     = num % den_g;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign quo     = (rs_neg ^ rt_neg) ? (32'd0 - q_u) : q_u;
  assign rem     = rs_neg ? (32'd0 - r_u) : r_u;

  // ---------------- result select ----------------
  hilo_t         res;
  logic [CW-1:0] load_cnt;

  always_comb begin
    res = arch;
    case (io.md_op)
      3'd0:       res = prod_s;
      3'd1:       res = prod_u;
      3'd2, 3'd3: begin
        // Divide-by-zero still runs the full busy period but commits old HI/LO.
        if (!div0) begin
          res.hi = rem;
          res.lo = quo;
        end
      end
      default:    res = arch;
    endcase
  end

  assign load_cnt = io.md_op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      arch   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            if (!io.md_op[2]) begin
              pend   <= res;
              cnt    <= load_cnt;
              state  <= BUSY;
              busy_q <= 1'b1;
            end else if (io.md_op == 3'd4) begin
              arch.hi <= io.rs_val;
            end else if (io.md_op == 3'd5) begin
              arch.lo <= io.rs_val;
            end
          end
        end
        BUSY: begin
          // start is ignored here; only the countdown advances.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            arch   <= pend;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy   = busy_q;
  assign io.hi_out = arch.hi;
  assign io.lo_out = arch.lo;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if mdi();

  mul_div_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (mdi.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int proto_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Architectural view: HI/LO, a pending pair, and how many busy cycles remain.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, up;
    rh = cur_hi; rl = cur_lo;
    case (op)
      3'd0: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); q = sa * sb;
        rh = q[63:32]; rl = q[31:0];
      end
      3'd1: begin
        ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub;
        rh = up[63:32]; rl = up[31:0];
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        rh = r[31:0]; rl = q[31:0];
      end
      3'd3: if (b != 0) begin
        rh = a % b; rl = a / b;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] rh, rl;
    if (!rst_n) begin
      m_hi <= 0; m_lo <= 0; p_hi <= 0; p_lo <= 0; m_left <= 0;
    end else if (m_left > 0) begin
      if (mdi.start) begin
        proto_err <= proto_err + 1;
        $display("note: start while busy (op %0d) ignored", mdi.md_op);
      end
      m_left <= m_left - 1;
      if (m_left == 1) begin m_hi <= p_hi; m_lo <= p_lo; end
    end else if (mdi.start) begin
      case (mdi.md_op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          ref_op(mdi.md_op, mdi.rs_val, mdi.rt_val, m_hi, m_lo, rh, rl);
          p_hi <= rh; p_lo <= rl;
          m_left <= (mdi.md_op < 3'd2) ? MULC : DIVC;
        end
        3'd4: m_hi <= mdi.rs_val;
        3'd5: m_lo <= mdi.rs_val;
        default: ;
      endcase
    end
  end

  // Every cycle out of reset, the DUT must match the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("cyc_busy", {31'd0, mdi.busy}, {31'd0, (m_left > 0)});
      chk("cyc_hi", mdi.hi_out, m_hi);
      chk("cyc_lo", mdi.lo_out, m_lo);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    mdi.start = 1'b1; mdi.md_op = op; mdi.rs_val = a; mdi.rt_val = b;
    @(posedge clk); #1;
    mdi.start = 1'b0;
    mdi.rs_val = $urandom; mdi.rt_val = $urandom;  // must not matter after sampling
  endtask

  // Counts busy cycles seen at negedges until busy drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!mdi.busy) return;
      n++;
    end
    total_cnt++;
    $display("FAIL wait_idle: busy still high after 64 cycles, expected low");
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    mdi.start = 0; mdi.md_op = 0; mdi.rs_val = 0; mdi.rt_val = 0;
    #3;
    chk("rst_busy", {31'd0, mdi.busy}, 32'd0);
    chk("rst_hi", mdi.hi_out, 32'd0);
    chk("rst_lo", mdi.lo_out, 32'd0);
    #20 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1. MULT -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    chk("t1_cycles", n, 5);
    chk("t1_hi", mdi.hi_out, 32'hFFFF_FFFF);
    chk("t1_lo", mdi.lo_out, 32'hFFFF_FFF1);

    // 2. MULTU max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("t2_cycles", n, 5);
    chk("t2_hi", mdi.hi_out, 32'hFFFF_FFFE);
    chk("t2_lo", mdi.lo_out, 32'h0000_0001);

    // 3. DIV -7 / 2, DIVU 7 / 2, DIV overflow case
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("t3_cycles", n, 10);
    chk("t3_lo", mdi.lo_out, 32'hFFFF_FFFD);
    chk("t3_hi", mdi.hi_out, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    chk("t3u_lo", mdi.lo_out, 32'd3);
    chk("t3u_hi", mdi.hi_out, 32'd1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", mdi.lo_out, 32'h8000_0000);
    chk("ovf_hi", mdi.hi_out, 32'd0);

    // 4. MTHI, then DIVU by zero
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("t4_busy", {31'd0, mdi.busy}, 32'd0);
    chk("t4_hi", mdi.hi_out, 32'h1234_5678);
    chk("t4_lo", mdi.lo_out, 32'h8000_0000);
    issue(3'd3, 32'd99, 32'd0);
    wait_idle(n);
    chk("t4_d0_cycles", n, 10);
    chk("t4_d0_hi", mdi.hi_out, 32'h1234_5678);
    chk("t4_d0_lo", mdi.lo_out, 32'h8000_0000);

    // 5. start during busy is ignored
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    mdi.start = 1'b1; mdi.md_op = 3'd5; mdi.rs_val = 32'hAA;
    @(posedge clk); #1;
    mdi.md_op = 3'd2; mdi.rs_val = 32'd100; mdi.rt_val = 32'd7;
    @(posedge clk); #1;
    mdi.start = 1'b0;
    wait_idle(n);
    chk("t5_cycles", n, 2);
    chk("t5_lo", mdi.lo_out, 32'd12);
    chk("t5_hi", mdi.hi_out, 32'd0);
    chk("t5_proto", proto_err, 2);
    repeat (3) @(negedge clk);
    chk("t5_stay_idle", {31'd0, mdi.busy}, 32'd0);

    // 6. async reset mid-DIV
    issue(3'd4, 32'h55, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, mdi.busy}, 32'd0);
    chk("t6_hi", mdi.hi_out, 32'd0);
    chk("t6_lo", mdi.lo_out, 32'd12 & 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_no_commit_hi", mdi.hi_out, 32'd0);
    chk("t6_no_commit_lo", mdi.lo_out, 32'd0);

    // Random ops, checked every cycle by the compare process.
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 9)); end
        2: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b);
      wait_idle(n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end
endmodule
